// File: rtl/snp_bus_ctrl.sv
// snp_bus_ctrl: snoop-bus controller for one cache's outbound coherence channel.
// Takes one request at a time from the requester (sdreq), snoops every peer (sureq/sdrsp),
// reads or writes memory as needed (mreq/mrsp), then returns a single response (sursp).
// Ports:
//   i_clk, i_rst                   clock, synchronous active-high reset
//   i_sdreq_* / o_sdreq_ready      requester request: op RD/RFO/INV/WB, block address, WB data
//   o_sursp_* / i_sursp_ready      requester response: OKAY/SNOOP/FETCH/FETCH_SHR plus data
//   o_sureq_* / i_sureq_ready      per-peer snoop request; op and address shared by all peers
//   i_sdrsp_* / o_sdrsp_ready      per-peer snoop response: MISS/HIT_CLN/HIT_DRTY plus data
//   o_mreq_* / i_mreq_ready        memory request (read or write)
//   i_mrsp_valid, i_mrsp_data      memory read data, always accepted
//   o_proto_err                    sticky protocol-error flag
module snp_bus_ctrl #(
  parameter int unsigned SADDR_WIDTH = 58,
  parameter int unsigned BLK_WIDTH   = 512,
  parameter int unsigned NUM_PEER    = 3
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_sdreq_valid,
  output logic                          o_sdreq_ready,
  input  logic [2:0]                    i_sdreq_op,
  input  logic [SADDR_WIDTH-1:0]        i_sdreq_addr,
  input  logic [BLK_WIDTH-1:0]          i_sdreq_data,
  output logic                          o_sursp_valid,
  input  logic                          i_sursp_ready,
  output logic [2:0]                    o_sursp_rsp,
  output logic [BLK_WIDTH-1:0]          o_sursp_data,
  output logic [NUM_PEER-1:0]           o_sureq_valid,
  input  logic [NUM_PEER-1:0]           i_sureq_ready,
  output logic [1:0]                    o_sureq_op,
  output logic [SADDR_WIDTH-1:0]        o_sureq_addr,
  input  logic [NUM_PEER-1:0]           i_sdrsp_valid,
  output logic [NUM_PEER-1:0]           o_sdrsp_ready,
  input  logic [2*NUM_PEER-1:0]         i_sdrsp_rsp,
  input  logic [BLK_WIDTH*NUM_PEER-1:0] i_sdrsp_data,
  output logic                          o_mreq_valid,
  input  logic                          i_mreq_ready,
  output logic                          o_mreq_we,
  output logic [SADDR_WIDTH-1:0]        o_mreq_addr,
  output logic [BLK_WIDTH-1:0]          o_mreq_data,
  input  logic                          i_mrsp_valid,
  input  logic [BLK_WIDTH-1:0]          i_mrsp_data,
  output logic                          o_proto_err
);

  localparam int unsigned IdxW = (NUM_PEER > 1) ? $clog2(NUM_PEER) : 1;

  localparam logic [2:0] OpRd  = 3'd0;
  localparam logic [2:0] OpRfo = 3'd1;
  localparam logic [2:0] OpInv = 3'd2;
  localparam logic [2:0] OpWb  = 3'd3;

  localparam logic [2:0] RspOkay     = 3'd0;
  localparam logic [2:0] RspSnoop    = 3'd1;
  localparam logic [2:0] RspFetch    = 3'd2;
  localparam logic [2:0] RspFetchShr = 3'd3;

  localparam logic [1:0] PeerMiss    = 2'd0;
  localparam logic [1:0] PeerHitCln  = 2'd1;
  localparam logic [1:0] PeerHitDrty = 2'd2;

  typedef enum logic [2:0] {StIdle, StBcast, StCollect, StMemWr, StMemRd, StResp} state_e;

  state_e                 r_state, w_state_nxt, w_post;
  logic                   r_live;
  logic [2:0]             r_op, w_op_nxt;
  logic [SADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [BLK_WIDTH-1:0]   r_data, w_data_nxt, w_peer_data;
  logic [NUM_PEER-1:0]    r_acc_mask, w_acc_nxt, w_acc_hs;
  logic [NUM_PEER-1:0]    r_rsp_mask, w_rspm_nxt, w_rsp_hs, w_rspm_fold;
  logic                   r_drty, w_drty_nxt, w_drty_fold;
  logic                   r_shr, w_shr_nxt, w_shr_fold;
  logic [IdxW-1:0]        r_drty_idx, w_idx_nxt, w_idx_fold;
  logic                   r_mreq_done, w_mreq_done_nxt;
  logic                   r_proto_err, w_err_nxt, w_rsp_err;

  // All control outputs decode registered state only.
  assign o_sdreq_ready = r_live & (r_state == StIdle);
  assign o_sureq_valid = (r_state == StBcast) ? ~r_acc_mask : '0;
  assign o_sureq_op    = r_op[1:0];
  assign o_sureq_addr  = r_addr;
  assign o_sdrsp_ready = (r_state == StBcast || r_state == StCollect) ? ~r_rsp_mask : '0;
  assign o_mreq_valid  = (r_state == StMemWr) | ((r_state == StMemRd) & ~r_mreq_done);
  assign o_mreq_we     = (r_state == StMemWr);
  assign o_mreq_addr   = r_addr;
  assign o_mreq_data   = r_data;
  assign o_sursp_valid = (r_state == StResp);
  assign o_sursp_data  = r_data;
  assign o_proto_err   = r_proto_err;

  assign w_acc_hs = o_sureq_valid & i_sureq_ready;
  assign w_rsp_hs = o_sdrsp_ready & i_sdrsp_valid;

  always_comb begin
    o_sursp_rsp = RspOkay;
    if (r_op == OpRd || r_op == OpRfo) begin
      if (r_drty)     o_sursp_rsp = RspSnoop;
      else if (r_shr) o_sursp_rsp = RspFetchShr;
      else            o_sursp_rsp = RspFetch;
    end
  end

  // Fold this cycle's peer responses into the flags; w_rsp_hs is zero outside BCAST/COLLECT.
  always_comb begin
    w_rspm_fold = r_rsp_mask | w_rsp_hs;
    w_drty_fold = r_drty;
    w_shr_fold  = r_shr;
    w_idx_fold  = r_drty_idx;
    w_peer_data = r_data;
    w_rsp_err   = 1'b0;
    for (int unsigned i = 0; i < NUM_PEER; i++) begin
      if (w_rsp_hs[i]) begin
        case (i_sdrsp_rsp[2*i +: 2])
          PeerMiss:   ;
          PeerHitCln: w_shr_fold = 1'b1;
          PeerHitDrty: begin
            // A second dirty copy is an error; keep the lowest-indexed peer's data regardless.
            if (!w_drty_fold || IdxW'(i) < w_idx_fold) begin
              w_peer_data = i_sdrsp_data[BLK_WIDTH*i +: BLK_WIDTH];
              w_idx_fold  = IdxW'(i);
            end
            if (w_drty_fold) w_rsp_err = 1'b1;
            w_drty_fold = 1'b1;
          end
          default:    w_rsp_err = 1'b1;
        endcase
      end
    end
  end

  // Where to go once every peer has responded.
  always_comb begin
    w_post = StResp;
    if (r_op == OpRd)                      w_post = w_drty_fold ? StMemWr : StMemRd;
    else if (r_op == OpRfo && !w_drty_fold) w_post = StMemRd;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_op_nxt        = r_op;
    w_addr_nxt      = r_addr;
    w_data_nxt      = w_peer_data;
    w_acc_nxt       = r_acc_mask | w_acc_hs;
    w_rspm_nxt      = w_rspm_fold;
    w_drty_nxt      = w_drty_fold;
    w_shr_nxt       = w_shr_fold;
    w_idx_nxt       = w_idx_fold;
    w_mreq_done_nxt = r_mreq_done;
    w_err_nxt       = r_proto_err | w_rsp_err;
    case (r_state)
      StIdle: begin
        if (i_sdreq_valid && o_sdreq_ready) begin
          w_op_nxt        = i_sdreq_op;
          w_addr_nxt      = i_sdreq_addr;
          w_data_nxt      = i_sdreq_data;
          w_acc_nxt       = '0;
          w_rspm_nxt      = '0;
          w_drty_nxt      = 1'b0;
          w_shr_nxt       = 1'b0;
          w_idx_nxt       = '0;
          w_mreq_done_nxt = 1'b0;
          unique case (i_sdreq_op)
            OpWb:               w_state_nxt = StMemWr;
            OpRd, OpRfo, OpInv: w_state_nxt = StBcast;
            default: begin
              w_err_nxt   = 1'b1;
              w_state_nxt = StResp;
            end
          endcase
        end
      end
      StBcast: begin
        // Last acceptance and last response together skip COLLECT.
        if (&w_acc_nxt) w_state_nxt = (&w_rspm_fold) ? w_post : StCollect;
      end
      StCollect: begin
        if (&w_rspm_fold) w_state_nxt = w_post;
      end
      StMemWr: begin
        if (i_mreq_ready) w_state_nxt = StResp;
      end
      StMemRd: begin
        if (!r_mreq_done) begin
          if (i_mreq_ready) w_mreq_done_nxt = 1'b1;
        end else if (i_mrsp_valid) begin
          w_data_nxt  = i_mrsp_data;
          w_state_nxt = StResp;
        end
      end
      StResp: begin
        if (i_sursp_ready) w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_live      <= 1'b0;
      r_op        <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_acc_mask  <= '0;
      r_rsp_mask  <= '0;
      r_drty      <= 1'b0;
      r_shr       <= 1'b0;
      r_drty_idx  <= '0;
      r_mreq_done <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_live      <= 1'b1;
      r_op        <= w_op_nxt;
      r_addr      <= w_addr_nxt;
      r_data      <= w_data_nxt;
      r_acc_mask  <= w_acc_nxt;
      r_rsp_mask  <= w_rspm_nxt;
      r_drty      <= w_drty_nxt;
      r_shr       <= w_shr_nxt;
      r_drty_idx  <= w_idx_nxt;
      r_mreq_done <= w_mreq_done_nxt;
      r_proto_err <= w_err_nxt;
    end
  end

endmodule

// File: tb/tb_snp_bus_ctrl.sv
// tb_snp_bus_ctrl: directed transaction table for snp_bus_ctrl. Each record describes the
// request, how peers and memory behave (delays, responses) and the expected outcome; a single
// task plays requester, peers and memory cycle by cycle and compares the result.
module tb_snp_bus_ctrl;
  localparam int unsigned AW = 58;
  localparam int unsigned DW = 512;
  localparam int unsigned NP = 3;

  localparam logic [DW-1:0] DAT_A    = {128{4'hA}};
  localparam logic [DW-1:0] DAT_C    = {128{4'hC}};
  localparam logic [DW-1:0] DAT_3    = {128{4'h3}};
  localparam logic [DW-1:0] DAT_5    = {128{4'h5}};
  localparam logic [DW-1:0] DAT_7    = {128{4'h7}};
  localparam logic [DW-1:0] DAT_1234 = {32{16'h1234}};

  logic            clk = 1'b0;
  logic            rst;
  logic            sdreq_valid, sdreq_ready;
  logic [2:0]      sdreq_op;
  logic [AW-1:0]   sdreq_addr;
  logic [DW-1:0]   sdreq_data;
  logic            sursp_valid, sursp_ready;
  logic [2:0]      sursp_rsp;
  logic [DW-1:0]   sursp_data;
  logic [NP-1:0]   sureq_valid, sureq_ready;
  logic [1:0]      sureq_op;
  logic [AW-1:0]   sureq_addr;
  logic [NP-1:0]   sdrsp_valid, sdrsp_ready;
  logic [2*NP-1:0] sdrsp_rsp;
  logic [DW*NP-1:0] sdrsp_data;
  logic            mreq_valid, mreq_ready, mreq_we;
  logic [AW-1:0]   mreq_addr;
  logic [DW-1:0]   mreq_data;
  logic            mrsp_valid;
  logic [DW-1:0]   mrsp_data;
  logic            proto_err;

  // Peer i always offers the same block: peer0 0x33.., peer1 0x55.., peer2 0x77..
  assign sdrsp_data = {DAT_7, DAT_5, DAT_3};

  snp_bus_ctrl #(.SADDR_WIDTH(AW), .BLK_WIDTH(DW), .NUM_PEER(NP)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_sdreq_valid(sdreq_valid), .o_sdreq_ready(sdreq_ready), .i_sdreq_op(sdreq_op),
    .i_sdreq_addr(sdreq_addr), .i_sdreq_data(sdreq_data),
    .o_sursp_valid(sursp_valid), .i_sursp_ready(sursp_ready), .o_sursp_rsp(sursp_rsp),
    .o_sursp_data(sursp_data),
    .o_sureq_valid(sureq_valid), .i_sureq_ready(sureq_ready), .o_sureq_op(sureq_op),
    .o_sureq_addr(sureq_addr),
    .i_sdrsp_valid(sdrsp_valid), .o_sdrsp_ready(sdrsp_ready), .i_sdrsp_rsp(sdrsp_rsp),
    .i_sdrsp_data(sdrsp_data),
    .o_mreq_valid(mreq_valid), .i_mreq_ready(mreq_ready), .o_mreq_we(mreq_we),
    .o_mreq_addr(mreq_addr), .o_mreq_data(mreq_data),
    .i_mrsp_valid(mrsp_valid), .i_mrsp_data(mrsp_data),
    .o_proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                 id;
    logic [2:0]         op;
    logic [AW-1:0]      addr;
    logic [DW-1:0]      wdata;
    logic [NP-1:0][1:0] prsp;       // peer response codes
    logic [NP-1:0][7:0] acc_dly;    // peer i raises sureq_ready from this cycle on
    logic [NP-1:0][7:0] rsp_at;     // earliest cycle peer i offers its response
    bit                 early;      // peers may respond in the same cycle they accept
    int                 mem_rdy_at;
    int                 mem_lat;    // extra cycles between read accept and mrsp
    logic [DW-1:0]      mdata;
    int                 sur_rdy_at;
    logic [2:0]         exp_rsp;
    bit                 chk_data;
    logic [DW-1:0]      exp_data;
    logic [1:0]         exp_sop;
    int                 exp_snp;    // snoop accepts/responses/valid drops per peer
    int                 exp_nrd;
    int                 exp_nwr;
    logic [DW-1:0]      exp_wr_data;
    bit                 exp_err;
    int                 exp_lat;    // cycle (handshake = 0) sursp_valid first rises
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t dflt(int id, logic [2:0] op, logic [AW-1:0] addr);
    vec_t v;
    v.id = id; v.op = op; v.addr = addr; v.wdata = '0;
    v.prsp = '0; v.acc_dly = '0; v.rsp_at = '0; v.early = 1'b0;
    v.mem_rdy_at = 0; v.mem_lat = 0; v.mdata = DAT_A; v.sur_rdy_at = 0;
    v.exp_rsp = 3'd2; v.chk_data = 1'b1; v.exp_data = DAT_A; v.exp_sop = op[1:0];
    v.exp_snp = 1; v.exp_nrd = 1; v.exp_nwr = 0; v.exp_wr_data = '0;
    v.exp_err = 1'b0; v.exp_lat = 5;
    return v;
  endfunction

  task automatic idle_inputs();
    sdreq_valid = 1'b0; sdreq_op = '0; sdreq_addr = '0; sdreq_data = '0;
    sureq_ready = '0; sdrsp_valid = '0; sdrsp_rsp = '0;
    mreq_ready = 1'b0; mrsp_valid = 1'b0; mrsp_data = '0; sursp_ready = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " sdreq_ready"}, DW'(sdreq_ready), '0);
    chk({tag, " sureq_valid"}, DW'(sureq_valid), '0);
    chk({tag, " sdrsp_ready"}, DW'(sdrsp_ready), '0);
    chk({tag, " mreq_valid"},  DW'(mreq_valid),  '0);
    chk({tag, " sursp_valid"}, DW'(sursp_valid), '0);
    chk({tag, " proto_err"},   DW'(proto_err),   '0);
  endtask

  // Entered and left at posedge+1; inputs change there, everything is observed at negedge.
  task automatic run_txn(input vec_t v, input int abort_at);
    int c = 0;
    bit done = 1'b0, req_done = 1'b0, late_sv = 1'b0, pay_bad = 1'b0, any_sv = 1'b0;
    bit [NP-1:0] acc_done = '0, rsp_done = '0, prev_sv = '0;
    int acc_cnt[NP], rsp_cnt[NP], fall_cnt[NP];
    int n_rd = 0, n_wr = 0, mrsp_at = -1, first_sur = -1;
    logic [DW-1:0] wr_data = '0, got_data = '0;
    logic [AW-1:0] rd_addr = '0, wr_addr = '0;
    logic [2:0] got_rsp = '0;
    string p;
    for (int i = 0; i < NP; i++) begin
      acc_cnt[i] = 0; rsp_cnt[i] = 0; fall_cnt[i] = 0;
    end
    p = $sformatf("v%0d", v.id);
    while (!done && c < 200) begin
      if (c == abort_at) begin
        rst = 1'b1;
        idle_inputs();
        return;
      end
      sdreq_valid = !req_done; sdreq_op = v.op; sdreq_addr = v.addr; sdreq_data = v.wdata;
      for (int i = 0; i < NP; i++) begin
        sureq_ready[i] = (c >= int'(v.acc_dly[i]));
        sdrsp_valid[i] = !rsp_done[i] && (c >= int'(v.rsp_at[i])) &&
                         (v.early ? (c >= 1) : acc_done[i]);
        sdrsp_rsp[2*i +: 2] = v.prsp[i];
      end
      mreq_ready = (c >= v.mem_rdy_at);
      mrsp_valid = (c == mrsp_at);
      mrsp_data = v.mdata;
      sursp_ready = (c >= v.sur_rdy_at);
      @(negedge clk);
      if (sdreq_valid && sdreq_ready) req_done = 1'b1;
      for (int i = 0; i < NP; i++) begin
        if (sureq_valid[i]) any_sv = 1'b1;
        if (prev_sv[i] && !sureq_valid[i]) fall_cnt[i]++;
        if (acc_done[i] && sureq_valid[i]) late_sv = 1'b1;
        if (sureq_valid[i] && sureq_ready[i]) begin
          acc_done[i] = 1'b1;
          acc_cnt[i]++;
          if (sureq_op !== v.exp_sop || sureq_addr !== v.addr) pay_bad = 1'b1;
        end
        if (sdrsp_valid[i] && sdrsp_ready[i]) begin
          rsp_done[i] = 1'b1;
          rsp_cnt[i]++;
        end
      end
      prev_sv = sureq_valid;
      if (mreq_valid && mreq_ready) begin
        if (mreq_we) begin
          n_wr++; wr_data = mreq_data; wr_addr = mreq_addr;
        end else begin
          n_rd++; rd_addr = mreq_addr; mrsp_at = c + 1 + v.mem_lat;
        end
      end
      if (sursp_valid && first_sur < 0) first_sur = c;
      if (sursp_valid && sursp_ready) begin
        done = 1'b1; got_rsp = sursp_rsp; got_data = sursp_data;
      end
      @(posedge clk);
      #1;
      c++;
    end
    idle_inputs();
    chk({p, " completed"}, DW'(done), DW'(1'b1));
    chk({p, " sursp_rsp"}, DW'(got_rsp), DW'(v.exp_rsp));
    if (v.chk_data) chk({p, " sursp_data"}, got_data, v.exp_data);
    chk({p, " sursp latency"}, DW'(first_sur), DW'(v.exp_lat));
    chk({p, " mem reads"}, DW'(n_rd), DW'(v.exp_nrd));
    if (v.exp_nrd > 0) chk({p, " read addr"}, DW'(rd_addr), DW'(v.addr));
    chk({p, " mem writes"}, DW'(n_wr), DW'(v.exp_nwr));
    if (v.exp_nwr > 0) begin
      chk({p, " write data"}, wr_data, v.exp_wr_data);
      chk({p, " write addr"}, DW'(wr_addr), DW'(v.addr));
    end
    chk({p, " proto_err"}, DW'(proto_err), DW'(v.exp_err));
    chk({p, " any sureq_valid"}, DW'(any_sv), DW'(v.exp_snp != 0));
    chk({p, " sureq after accept"}, DW'(late_sv), '0);
    chk({p, " sureq payload"}, DW'(pay_bad), '0);
    for (int i = 0; i < NP; i++) begin
      chk($sformatf("%s peer%0d snoop accepts", p, i), DW'(acc_cnt[i]), DW'(v.exp_snp));
      chk($sformatf("%s peer%0d rsp accepts", p, i), DW'(rsp_cnt[i]), DW'(v.exp_snp));
      chk($sformatf("%s peer%0d sureq drops", p, i), DW'(fall_cnt[i]), DW'(v.exp_snp));
    end
  endtask

  vec_t vecs[10];
  vec_t hv;

  initial begin
    // RD, all peers miss: memory fetch.
    vecs[0] = dflt(0, 3'd0, 58'h40);
    // RD, peer1 dirty: write-back of the peer data, SNOOP response.
    vecs[1] = dflt(1, 3'd0, 58'h41);
    vecs[1].prsp[1] = 2'd2; vecs[1].exp_rsp = 3'd1; vecs[1].exp_data = DAT_5;
    vecs[1].exp_nrd = 0; vecs[1].exp_nwr = 1; vecs[1].exp_wr_data = DAT_5; vecs[1].exp_lat = 4;
    // RFO, peer0 clean: memory fetch with shared peer copy.
    vecs[2] = dflt(2, 3'd1, 58'h80);
    vecs[2].prsp[0] = 2'd1; vecs[2].mdata = DAT_C; vecs[2].exp_data = DAT_C;
    vecs[2].exp_rsp = 3'd3;
    // WB: straight to memory, no snoops.
    vecs[3] = dflt(3, 3'd3, 58'h123);
    vecs[3].wdata = DAT_1234; vecs[3].exp_snp = 0; vecs[3].exp_nrd = 0; vecs[3].exp_nwr = 1;
    vecs[3].exp_wr_data = DAT_1234; vecs[3].exp_rsp = 3'd0; vecs[3].chk_data = 1'b0;
    vecs[3].exp_lat = 2;
    // INV: snoop only.
    vecs[4] = dflt(4, 3'd2, 58'h200);
    vecs[4].exp_rsp = 3'd0; vecs[4].chk_data = 1'b0; vecs[4].exp_nrd = 0; vecs[4].exp_lat = 3;
    // INV with acceptance and response in the same BCAST cycle: COLLECT skipped.
    vecs[5] = vecs[4]; vecs[5].id = 5; vecs[5].addr = 58'h201; vecs[5].early = 1'b1;
    vecs[5].exp_lat = 2;
    // Staggered: accepts at cycles 1/3/5, responses 2,0,1, slow memory, sursp_ready low 4 cycles.
    vecs[6] = dflt(6, 3'd0, 58'h300);
    vecs[6].acc_dly[1] = 8'd3; vecs[6].acc_dly[2] = 8'd5;
    vecs[6].rsp_at[0] = 8'd7; vecs[6].rsp_at[1] = 8'd8; vecs[6].rsp_at[2] = 8'd6;
    vecs[6].mem_lat = 2; vecs[6].sur_rdy_at = 17; vecs[6].exp_lat = 13;
    // RFO, peer2 dirty, peer0 clean: no write-back, SNOOP with peer2 data.
    vecs[7] = dflt(7, 3'd1, 58'h400);
    vecs[7].prsp[0] = 2'd1; vecs[7].prsp[2] = 2'd2; vecs[7].exp_rsp = 3'd1;
    vecs[7].exp_data = DAT_7; vecs[7].exp_nrd = 0; vecs[7].exp_lat = 3;
    // RD, peers 0 and 2 dirty (peer2 first): error, peer0 data kept and written back.
    vecs[8] = dflt(8, 3'd0, 58'h500);
    vecs[8].prsp[0] = 2'd2; vecs[8].prsp[2] = 2'd2; vecs[8].rsp_at[0] = 8'd4;
    vecs[8].exp_err = 1'b1; vecs[8].exp_rsp = 3'd1; vecs[8].exp_data = DAT_3;
    vecs[8].exp_nrd = 0; vecs[8].exp_nwr = 1; vecs[8].exp_wr_data = DAT_3; vecs[8].exp_lat = 6;
    // Reserved op: OKAY straight away, error stays set.
    vecs[9] = dflt(9, 3'd5, 58'h600);
    vecs[9].exp_snp = 0; vecs[9].exp_nrd = 0; vecs[9].exp_rsp = 3'd0; vecs[9].chk_data = 1'b0;
    vecs[9].exp_err = 1'b1; vecs[9].exp_lat = 1;

    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("por");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("por ready in release cycle", DW'(sdreq_ready), '0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("por ready after release", DW'(sdreq_ready), DW'(1'b1));
    @(posedge clk); #1;

    for (int k = 0; k < 10; k++) run_txn(vecs[k], -1);

    // Reset while waiting for memory read data; the txn is abandoned at cycle 4 (MEM_RD).
    hv = dflt(10, 3'd0, 58'h700);
    hv.mem_lat = 5;
    run_txn(hv, 4);
    @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("mid MEM_RD reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready in release cycle", DW'(sdreq_ready), '0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("ready after release", DW'(sdreq_ready), DW'(1'b1));
    @(posedge clk); #1;

    hv = dflt(11, 3'd0, 58'h40);
    hv.mdata = DAT_C; hv.exp_data = DAT_C;
    run_txn(hv, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
